// File: rtl/power_switch_ctrl.sv
// Staged power-switch controller: turns N_STAGES switch segments on (wake)
// or off (sleep) one at a time with a programmable spacing, and answers the
// power-gate sequencer with a level acknowledge once the state is reached.
// Optional build macro: PSW_CHAIN_ACK_EN adds the sw_chain_ack input and
// gates the final ON/OFF transition on the switch daisy-chain acknowledge.
module power_switch_ctrl #(
    parameter int N_STAGES = 4,
    parameter int DLY_W    = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sleep_req,
    output logic                sleep_ack,
    input  logic [DLY_W-1:0]    dly_cfg,
    output logic [N_STAGES-1:0] sw_en,
    output logic                busy
`ifdef PSW_CHAIN_ACK_EN
    ,
    input  logic                sw_chain_ack
`endif
);

    // Three-bit encoding leaves spare codes; any of them recovers via PWR_DN.
    typedef enum logic [2:0] {
        ST_OFF    = 3'd0,
        ST_PWR_UP = 3'd1,
        ST_ON     = 3'd2,
        ST_PWR_DN = 3'd3
    } state_t;

    state_t              state_reg, state_next;
    logic [DLY_W-1:0]    cnt_reg, cnt_next;
    logic [N_STAGES-1:0] sw_en_reg, sw_en_next;
    logic                ack_reg, ack_next;
    logic                busy_reg, busy_next;

    logic [N_STAGES-1:0] sw_up;
    logic [N_STAGES-1:0] sw_dn;
    logic                all_on;
    logic                all_off;
    logic                chain_hi;
    logic                chain_lo;

    // One-step thermometer neighbours: sw_up turns on the lowest clear
    // segment, sw_dn turns off the highest set one.
    for (genvar gi = 0; gi < N_STAGES; gi++) begin : g_step
        if (gi == 0) begin : g_up_lo
            assign sw_up[gi] = 1'b1;
        end else begin : g_up_hi
            assign sw_up[gi] = sw_en_reg[gi-1];
        end
        if (gi == N_STAGES - 1) begin : g_dn_hi
            assign sw_dn[gi] = 1'b0;
        end else begin : g_dn_lo
            assign sw_dn[gi] = sw_en_reg[gi+1];
        end
    end

    assign all_on  = &sw_en_reg;
    assign all_off = ~|sw_en_reg;

`ifdef PSW_CHAIN_ACK_EN
    // The last switch cell must confirm the chain before the state is final.
    assign chain_hi = sw_chain_ack;
    assign chain_lo = ~sw_chain_ack;
`else
    assign chain_hi = 1'b1;
    assign chain_lo = 1'b1;
`endif

    // State and output registers; reset drops every switch at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= ST_OFF;
            cnt_reg   <= '0;
            sw_en_reg <= '0;
            ack_reg   <= 1'b1;
            busy_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            sw_en_reg <= sw_en_next;
            ack_reg   <= ack_next;
            busy_reg  <= busy_next;
        end
    end

    // Next-state logic: counter-spaced stepping, reversals and final handshakes.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        sw_en_next = sw_en_reg;
        ack_next   = ack_reg;
        busy_next  = busy_reg;
        case (state_reg)
            ST_OFF: begin
                if (!sleep_req) begin
                    state_next = ST_PWR_UP;
                    sw_en_next = sw_up;
                    cnt_next   = dly_cfg;
                    busy_next  = 1'b1;
                end
            end
            ST_PWR_UP: begin
                busy_next = 1'b1;
                if (sleep_req) begin
                    state_next = ST_PWR_DN;
                    sw_en_next = sw_dn;
                    cnt_next   = dly_cfg;
                end else if (cnt_reg != '0) begin
                    cnt_next = cnt_reg - DLY_W'(1);
                end else if (!all_on) begin
                    sw_en_next = sw_up;
                    cnt_next   = dly_cfg;
                end else if (chain_hi) begin
                    state_next = ST_ON;
                    ack_next   = 1'b0;
                    busy_next  = 1'b0;
                end
            end
            ST_ON: begin
                if (sleep_req) begin
                    state_next = ST_PWR_DN;
                    sw_en_next = sw_dn;
                    cnt_next   = dly_cfg;
                    busy_next  = 1'b1;
                end
            end
            ST_PWR_DN: begin
                busy_next = 1'b1;
                if (!sleep_req) begin
                    state_next = ST_PWR_UP;
                    sw_en_next = sw_up;
                    cnt_next   = dly_cfg;
                end else if (cnt_reg != '0) begin
                    cnt_next = cnt_reg - DLY_W'(1);
                end else if (!all_off) begin
                    sw_en_next = sw_dn;
                    cnt_next   = dly_cfg;
                end else if (chain_lo) begin
                    state_next = ST_OFF;
                    ack_next   = 1'b1;
                    busy_next  = 1'b0;
                end
            end
            default: begin
                // Corrupted state: power down safely from whatever is on now.
                state_next = ST_PWR_DN;
                cnt_next   = dly_cfg;
                busy_next  = 1'b1;
            end
        endcase
    end

    // Outputs come straight from registers.
    always_comb begin
        sw_en     = sw_en_reg;
        sleep_ack = ack_reg;
        busy      = busy_reg;
    end

endmodule

// File: tb/tb_power_switch_ctrl.sv
// Scoreboard bench for power_switch_ctrl (N_STAGES=4, DLY_W=4). Each task
// pushes the per-cycle expected outputs when it drives stimulus, then pops
// and compares them one clock at a time.
module tb_power_switch_ctrl;

    logic       clk;
    logic       rst;
    logic       sleep_req;
    logic [3:0] dly_cfg;
    logic [3:0] sw_en;
    logic       sleep_ack;
    logic       busy;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [3:0] sw;
        logic       ack;
        logic       busy;
    } exp_t;

    exp_t sb[$];

`ifdef PSW_CHAIN_ACK_EN
    logic sw_chain_ack;
    logic chain_force;
    logic chain_val;
    // Default chain behaviour: acknowledge follows the last segment.
    assign sw_chain_ack = chain_force ? chain_val : sw_en[3];
`endif

    power_switch_ctrl #(.N_STAGES(4), .DLY_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .sleep_req (sleep_req),
        .sleep_ack (sleep_ack),
        .dly_cfg   (dly_cfg),
        .sw_en     (sw_en),
        .busy      (busy)
`ifdef PSW_CHAIN_ACK_EN
        ,
        .sw_chain_ack (sw_chain_ack)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] therm(input int n);
        logic [4:0] t;
        t = (5'd1 << n) - 5'd1;
        return t[3:0];
    endfunction

    task automatic push_exp(input logic [3:0] sw, input logic ack, input logic bsy);
        exp_t e;
        e.sw = sw;
        e.ack = ack;
        e.busy = bsy;
        sb.push_back(e);
    endtask

    task automatic test_reset();
        exp_t e;
        rst = 1'b1;
        sleep_req = 1'b1;
        dly_cfg = 4'd2;
        #2 rst = 1'b0;
        #1;
        checks += 3;
        if (sw_en !== 4'b0000) begin failures++; $display("FAIL reset sw_en got %b want 0000", sw_en); end
        if (sleep_ack !== 1'b1) begin failures++; $display("FAIL reset sleep_ack got %b want 1", sleep_ack); end
        if (busy !== 1'b0) begin failures++; $display("FAIL reset busy got %b want 0", busy); end
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        for (int k = 0; k < 3; k++) push_exp(4'b0000, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            e = sb.pop_front();
            checks += 3;
            $display("txn reset_idle step %0d sw_en=%b ack=%b busy=%b", k, sw_en, sleep_ack, busy);
            if (sw_en !== e.sw) begin failures++; $display("FAIL reset_idle sw_en step %0d got %b want %b", k, sw_en, e.sw); end
            if (sleep_ack !== e.ack) begin failures++; $display("FAIL reset_idle ack step %0d got %b want %b", k, sleep_ack, e.ack); end
            if (busy !== e.busy) begin failures++; $display("FAIL reset_idle busy step %0d got %b want %b", k, busy, e.busy); end
        end
    endtask

    task automatic test_wake();
        exp_t e;
        // dly_cfg=2: a new segment every 3 cycles, ack 13 edges after the drive.
        @(negedge clk);
        dly_cfg = 4'd2;
        sleep_req = 1'b0;
        for (int k = 0; k < 12; k++) push_exp(therm(k / 3 + 1), 1'b1, 1'b1);
        push_exp(4'b1111, 1'b0, 1'b0);
        for (int k = 0; k < 13; k++) begin
            @(posedge clk); #1;
            e = sb.pop_front();
            checks += 3;
            $display("txn wake step %0d sw_en=%b ack=%b busy=%b", k, sw_en, sleep_ack, busy);
            if (sw_en !== e.sw) begin failures++; $display("FAIL wake sw_en step %0d got %b want %b", k, sw_en, e.sw); end
            if (sleep_ack !== e.ack) begin failures++; $display("FAIL wake ack step %0d got %b want %b", k, sleep_ack, e.ack); end
            if (busy !== e.busy) begin failures++; $display("FAIL wake busy step %0d got %b want %b", k, busy, e.busy); end
        end
    endtask

    task automatic test_sleep();
        exp_t e;
        @(negedge clk);
        dly_cfg = 4'd0;
        sleep_req = 1'b1;
        for (int k = 0; k < 4; k++) push_exp(therm(3 - k), 1'b0, 1'b1);
        push_exp(4'b0000, 1'b1, 1'b0);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            e = sb.pop_front();
            checks += 3;
            $display("txn sleep step %0d sw_en=%b ack=%b busy=%b", k, sw_en, sleep_ack, busy);
            if (sw_en !== e.sw) begin failures++; $display("FAIL sleep sw_en step %0d got %b want %b", k, sw_en, e.sw); end
            if (sleep_ack !== e.ack) begin failures++; $display("FAIL sleep ack step %0d got %b want %b", k, sleep_ack, e.ack); end
            if (busy !== e.busy) begin failures++; $display("FAIL sleep busy step %0d got %b want %b", k, busy, e.busy); end
        end
    endtask

    task automatic test_reversal();
        exp_t e;
        // Wake with dly_cfg=1, reverse while sw_en=0011.
        @(negedge clk);
        dly_cfg = 4'd1;
        sleep_req = 1'b0;
        push_exp(4'b0001, 1'b1, 1'b1);
        push_exp(4'b0001, 1'b1, 1'b1);
        push_exp(4'b0011, 1'b1, 1'b1);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            e = sb.pop_front();
            checks += 3;
            $display("txn rev_up step %0d sw_en=%b ack=%b busy=%b", k, sw_en, sleep_ack, busy);
            if (sw_en !== e.sw) begin failures++; $display("FAIL rev_up sw_en step %0d got %b want %b", k, sw_en, e.sw); end
            if (sleep_ack !== e.ack) begin failures++; $display("FAIL rev_up ack step %0d got %b want %b", k, sleep_ack, e.ack); end
            if (busy !== e.busy) begin failures++; $display("FAIL rev_up busy step %0d got %b want %b", k, busy, e.busy); end
        end
        @(negedge clk);
        sleep_req = 1'b1;
        push_exp(4'b0001, 1'b1, 1'b1);
        push_exp(4'b0001, 1'b1, 1'b1);
        push_exp(4'b0000, 1'b1, 1'b1);
        push_exp(4'b0000, 1'b1, 1'b1);
        push_exp(4'b0000, 1'b1, 1'b0);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            e = sb.pop_front();
            checks += 3;
            $display("txn rev_dn step %0d sw_en=%b ack=%b busy=%b", k, sw_en, sleep_ack, busy);
            if (sw_en !== e.sw) begin failures++; $display("FAIL rev_dn sw_en step %0d got %b want %b", k, sw_en, e.sw); end
            if (sleep_ack !== e.ack) begin failures++; $display("FAIL rev_dn ack step %0d got %b want %b", k, sleep_ack, e.ack); end
            if (busy !== e.busy) begin failures++; $display("FAIL rev_dn busy step %0d got %b want %b", k, busy, e.busy); end
        end
    endtask

    task automatic test_dly_change();
        exp_t e;
        // Interval loaded with 3 runs 4 cycles even though dly_cfg drops to 0.
        @(negedge clk);
        dly_cfg = 4'd3;
        sleep_req = 1'b0;
        push_exp(4'b0001, 1'b1, 1'b1);
        push_exp(4'b0001, 1'b1, 1'b1);
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            e = sb.pop_front();
            checks += 3;
            $display("txn dly_a step %0d sw_en=%b ack=%b busy=%b", k, sw_en, sleep_ack, busy);
            if (sw_en !== e.sw) begin failures++; $display("FAIL dly_a sw_en step %0d got %b want %b", k, sw_en, e.sw); end
            if (sleep_ack !== e.ack) begin failures++; $display("FAIL dly_a ack step %0d got %b want %b", k, sleep_ack, e.ack); end
            if (busy !== e.busy) begin failures++; $display("FAIL dly_a busy step %0d got %b want %b", k, busy, e.busy); end
        end
        @(negedge clk);
        dly_cfg = 4'd0;
        push_exp(4'b0001, 1'b1, 1'b1);
        push_exp(4'b0001, 1'b1, 1'b1);
        push_exp(4'b0011, 1'b1, 1'b1);
        push_exp(4'b0111, 1'b1, 1'b1);
        push_exp(4'b1111, 1'b1, 1'b1);
        push_exp(4'b1111, 1'b0, 1'b0);
        for (int k = 2; k < 8; k++) begin
            @(posedge clk); #1;
            e = sb.pop_front();
            checks += 3;
            $display("txn dly_b step %0d sw_en=%b ack=%b busy=%b", k, sw_en, sleep_ack, busy);
            if (sw_en !== e.sw) begin failures++; $display("FAIL dly_b sw_en step %0d got %b want %b", k, sw_en, e.sw); end
            if (sleep_ack !== e.ack) begin failures++; $display("FAIL dly_b ack step %0d got %b want %b", k, sleep_ack, e.ack); end
            if (busy !== e.busy) begin failures++; $display("FAIL dly_b busy step %0d got %b want %b", k, busy, e.busy); end
        end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        // From ON, start powering down, then assert reset between clock edges.
        @(negedge clk);
        dly_cfg = 4'd0;
        sleep_req = 1'b1;
        push_exp(4'b0111, 1'b0, 1'b1);
        @(posedge clk); #1;
        e = sb.pop_front();
        checks += 3;
        $display("txn rst_mid pre sw_en=%b ack=%b busy=%b", sw_en, sleep_ack, busy);
        if (sw_en !== e.sw) begin failures++; $display("FAIL rst_mid_pre sw_en got %b want %b", sw_en, e.sw); end
        if (sleep_ack !== e.ack) begin failures++; $display("FAIL rst_mid_pre ack got %b want %b", sleep_ack, e.ack); end
        if (busy !== e.busy) begin failures++; $display("FAIL rst_mid_pre busy got %b want %b", busy, e.busy); end
        #2 rst = 1'b0;
        #1;
        checks += 3;
        $display("txn rst_mid async sw_en=%b ack=%b busy=%b", sw_en, sleep_ack, busy);
        if (sw_en !== 4'b0000) begin failures++; $display("FAIL rst_mid sw_en got %b want 0000", sw_en); end
        if (sleep_ack !== 1'b1) begin failures++; $display("FAIL rst_mid ack got %b want 1", sleep_ack); end
        if (busy !== 1'b0) begin failures++; $display("FAIL rst_mid busy got %b want 0", busy); end
        @(negedge clk);
        rst = 1'b1;
        push_exp(4'b0000, 1'b1, 1'b0);
        @(posedge clk); #1;
        e = sb.pop_front();
        checks += 3;
        $display("txn rst_mid post sw_en=%b ack=%b busy=%b", sw_en, sleep_ack, busy);
        if (sw_en !== e.sw) begin failures++; $display("FAIL rst_mid_post sw_en got %b want %b", sw_en, e.sw); end
        if (sleep_ack !== e.ack) begin failures++; $display("FAIL rst_mid_post ack got %b want %b", sleep_ack, e.ack); end
        if (busy !== e.busy) begin failures++; $display("FAIL rst_mid_post busy got %b want %b", busy, e.busy); end
    endtask

`ifdef PSW_CHAIN_ACK_EN
    task automatic test_chain_ack();
        exp_t e;
        // Wake with the chain acknowledge withheld: hold at 1111, busy.
        @(negedge clk);
        chain_force = 1'b1;
        chain_val = 1'b0;
        dly_cfg = 4'd0;
        sleep_req = 1'b0;
        for (int k = 0; k < 4; k++) push_exp(therm(k + 1), 1'b1, 1'b1);
        for (int k = 4; k < 10; k++) push_exp(4'b1111, 1'b1, 1'b1);
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            e = sb.pop_front();
            checks += 3;
            $display("txn chain_up step %0d sw_en=%b ack=%b busy=%b", k, sw_en, sleep_ack, busy);
            if (sw_en !== e.sw) begin failures++; $display("FAIL chain_up sw_en step %0d got %b want %b", k, sw_en, e.sw); end
            if (sleep_ack !== e.ack) begin failures++; $display("FAIL chain_up ack step %0d got %b want %b", k, sleep_ack, e.ack); end
            if (busy !== e.busy) begin failures++; $display("FAIL chain_up busy step %0d got %b want %b", k, busy, e.busy); end
        end
        @(negedge clk);
        chain_val = 1'b1;
        push_exp(4'b1111, 1'b0, 1'b0);
        // Then sleep with the chain still reporting on: wait at 0000.
        for (int k = 0; k < 4; k++) push_exp(therm(3 - k), 1'b0, 1'b1);
        for (int k = 4; k < 7; k++) push_exp(4'b0000, 1'b0, 1'b1);
        @(posedge clk); #1;
        e = sb.pop_front();
        checks += 3;
        $display("txn chain_on sw_en=%b ack=%b busy=%b", sw_en, sleep_ack, busy);
        if (sw_en !== e.sw) begin failures++; $display("FAIL chain_on sw_en got %b want %b", sw_en, e.sw); end
        if (sleep_ack !== e.ack) begin failures++; $display("FAIL chain_on ack got %b want %b", sleep_ack, e.ack); end
        if (busy !== e.busy) begin failures++; $display("FAIL chain_on busy got %b want %b", busy, e.busy); end
        @(negedge clk);
        sleep_req = 1'b1;
        for (int k = 0; k < 7; k++) begin
            @(posedge clk); #1;
            e = sb.pop_front();
            checks += 3;
            $display("txn chain_dn step %0d sw_en=%b ack=%b busy=%b", k, sw_en, sleep_ack, busy);
            if (sw_en !== e.sw) begin failures++; $display("FAIL chain_dn sw_en step %0d got %b want %b", k, sw_en, e.sw); end
            if (sleep_ack !== e.ack) begin failures++; $display("FAIL chain_dn ack step %0d got %b want %b", k, sleep_ack, e.ack); end
            if (busy !== e.busy) begin failures++; $display("FAIL chain_dn busy step %0d got %b want %b", k, busy, e.busy); end
        end
        @(negedge clk);
        chain_val = 1'b0;
        push_exp(4'b0000, 1'b1, 1'b0);
        @(posedge clk); #1;
        e = sb.pop_front();
        checks += 3;
        $display("txn chain_off sw_en=%b ack=%b busy=%b", sw_en, sleep_ack, busy);
        if (sw_en !== e.sw) begin failures++; $display("FAIL chain_off sw_en got %b want %b", sw_en, e.sw); end
        if (sleep_ack !== e.ack) begin failures++; $display("FAIL chain_off ack got %b want %b", sleep_ack, e.ack); end
        if (busy !== e.busy) begin failures++; $display("FAIL chain_off busy got %b want %b", busy, e.busy); end
        chain_force = 1'b0;
    endtask
`endif

    initial begin
`ifdef PSW_CHAIN_ACK_EN
        chain_force = 1'b0;
        chain_val = 1'b0;
`endif
        test_reset();
        test_wake();
        test_sleep();
        test_reversal();
        test_dly_change();
        test_reset_mid();
`ifdef PSW_CHAIN_ACK_EN
        test_chain_ack();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
